// File: rtl/snn_wishbone_dual_core.sv
// Wishbone slave holding two 256-axon / 256-neuron integrate-and-fire
// cores; a trigger read evaluates both cores into the output spike words.
module snn_wishbone_dual_core (
  input  logic        clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);
  localparam int NUM_CORES   = 2;
  localparam int NUM_AXONS   = 256;
  localparam int NUM_NEURONS = 256;
  localparam int PARAM_W     = 368;

  logic [NUM_AXONS-1:0]   imem_q  [NUM_CORES];
  logic [NUM_NEURONS-1:0] omem_q  [NUM_CORES];
  logic [PARAM_W-1:0]     param_q [NUM_CORES][NUM_NEURONS];
  logic                   ack_q;
  logic [31:0]            dat_q;

  logic        acc;
  logic        core;
  logic [14:0] region;
  logic [2:0]  wsel;
  logic [7:0]  nsel;
  logic [3:0]  pw;
  logic [7:0]  isel;
  logic [8:0]  psel;
  logic        aligned;
  logic        is_imem;
  logic        is_par;
  logic        is_omem;
  logic        is_trig;
  logic        unused_sel;

  assign acc     = wbs_cyc_i & wbs_stb_i;
  assign core    = wbs_adr_i[16];
  assign region  = wbs_adr_i[31:17];
  assign wsel    = wbs_adr_i[4:2];
  assign nsel    = wbs_adr_i[15:8];
  assign pw      = wbs_adr_i[5:2];
  assign isel    = {~wsel, 5'h1f};
  assign psel    = 9'd367 - {pw, 5'd0};
  assign aligned = wbs_adr_i[1:0] == 2'b00;
  assign is_imem = aligned && region == 15'h4000
                && wbs_adr_i[15:5] == 11'd0;
  assign is_par  = aligned && region == 15'h4001
                && wbs_adr_i[7:6] == 2'b00 && pw <= 4'd11;
  assign is_omem = aligned && region == 15'h4002
                && wbs_adr_i[15:5] == 11'd0;
  assign is_trig = wbs_adr_i == 32'h8036_0000;
  assign unused_sel = ^wbs_sel_i;

  function automatic logic [17:0] sx(input logic [8:0] x);
    return {{9{x[8]}}, x};
  endfunction

  function automatic logic fire(
    input logic [NUM_AXONS-1:0] s,
    input logic [PARAM_W-1:0]   p
  );
    logic [NUM_AXONS-1:0] m;
    logic signed [17:0]   w [4];
    logic signed [17:0]   v;
    logic [7:0]           ax;
    m    = p[367:112];
    w[0] = sx(p[93:85]);
    w[1] = sx(p[84:76]);
    w[2] = sx(p[75:67]);
    w[3] = sx(p[66:58]);
    v    = sx(p[111:103]) + sx(p[57:49]);
    for (int i = 0; i < NUM_AXONS; i++) begin
      ax = 8'(i);
      if (s[ax] && m[ax]) v = v + w[ax[1:0]];
    end
    return v >= $signed(sx(p[48:40]));
  endfunction

  function automatic logic [NUM_NEURONS-1:0] eval_core(
    input logic [NUM_AXONS-1:0] s,
    input logic [PARAM_W-1:0]   ps [NUM_NEURONS]
  );
    logic [NUM_NEURONS-1:0] r;
    logic [7:0]             nj;
    r = '0;
    for (int j = 0; j < NUM_NEURONS; j++) begin
      nj    = 8'(j);
      r[nj] = fire(s, ps[nj]);
    end
    return r;
  endfunction

  // Parameter RAM keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (acc && wbs_we_i && is_par) begin
      if (pw == 4'd11)
        param_q[core][nsel][15:0] <= wbs_dat_i[31:16];
      else
        param_q[core][nsel][psel -: 32] <= wbs_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      imem_q <= '{default: '0};
      omem_q <= '{default: '0};
    end else begin
      ack_q <= acc;
      dat_q <= '0;
      if (acc && wbs_we_i && is_imem)
        imem_q[core][isel -: 32] <= wbs_dat_i;
      if (acc && !wbs_we_i) begin
        unique case (1'b1)
          is_imem: dat_q <= imem_q[core][isel -: 32];
          is_omem: dat_q <= omem_q[core][isel -: 32];
          is_trig: begin
            omem_q[0] <= eval_core(imem_q[0], param_q[0]);
            omem_q[1] <= eval_core(imem_q[1], param_q[1]);
          end
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
endmodule

// File: tb/tb_snn_wishbone_dual_core.sv
// Scoreboard bench for snn_wishbone_dual_core: expected read words are
// queued as each access is issued and compared once the ack arrives.
module tb_snn_wishbone_dual_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic        ack;
  logic [31:0] rdat;

  always #5 clk = ~clk;

  snn_wishbone_dual_core dut (
    .clk_i     (clk),
    .wb_rst_i  (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0]  exp_q [$];
  logic [31:0]  act_q [$];
  bit           ok_q  [$];
  logic [367:0] mp [2][256];
  logic [255:0] ms [2];
  logic [255:0] momem [2];

  function automatic int sx(input logic [8:0] x);
    return int'($signed(x));
  endfunction

  function automatic logic model_fire(input logic [255:0] s,
                                      input logic [367:0] p);
    int v;
    int wt [4];
    wt[0] = sx(p[93:85]);
    wt[1] = sx(p[84:76]);
    wt[2] = sx(p[75:67]);
    wt[3] = sx(p[66:58]);
    v = sx(p[111:103]) + sx(p[57:49]);
    for (int a = 0; a < 256; a++)
      if (s[a] && p[112+a]) v += wt[a%4];
    return v >= sx(p[48:40]);
  endfunction

  task automatic model_trigger();
    for (int c = 0; c < 2; c++)
      for (int n = 0; n < 256; n++)
        momem[c][n] = model_fire(ms[c], mp[c][n]);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    bit got;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = a; wdat = d; sel = 4'($urandom);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      if (ack) got = 1;
      else begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL write_ack adr %h: ack 0, required 1", a);
    end
  endtask

  task automatic wb_read(input logic [31:0] a,
                         output logic [31:0] d, output bit ok);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = a; sel = 4'($urandom);
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    ok = 0;
    d  = '0;
    for (int i = 0; i < 4 && !ok; i++) begin
      if (ack) begin ok = 1; d = rdat; end
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d;
    bit ok;
    exp_q.push_back(e);
    wb_read(a, d, ok);
    act_q.push_back(d);
    ok_q.push_back(ok);
  endtask

  task automatic issue_omem_reads();
    logic [7:0] b;
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < 8; w++) begin
        b = 8'(255 - 32*w);
        issue_read(32'h8004_0000 + (32'(c) << 16) + 32'(4*w),
                   momem[c][b -: 32]);
      end
  endtask

  task automatic do_trigger();
    model_trigger();
    issue_read(32'h8036_0000, 32'h0);
  endtask

  task automatic set_imem(input int c, input int w, input logic [31:0] d);
    logic [7:0] b;
    b = 8'(255 - 32*w);
    ms[c][b -: 32] = d;
    wb_write(32'h8000_0000 + (32'(c) << 16) + 32'(4*w), d);
  endtask

  task automatic set_neuron(input int c, input int n,
                            input logic [255:0] mask,
                            input int v0, input int leak,
                            input int w0, input int w1,
                            input int w2, input int w3,
                            input int thr);
    logic [367:0] p;
    logic [31:0]  base;
    p = {mask, 9'(v0), 9'($urandom), 9'(w0), 9'(w1), 9'(w2), 9'(w3),
         9'(leak), 9'(thr), 9'($urandom), 31'($urandom)};
    mp[c][n] = p;
    base = 32'h8002_0000 + (32'(c) << 16) + (32'(n) << 8);
    for (int k = 0; k < 11; k++)
      wb_write(base + 32'(4*k), p[367-32*k -: 32]);
    wb_write(base + 32'd44, {p[15:0], 16'($urandom)});
  endtask

  task automatic test_reset();
    logic [31:0] e, a;
    bit k;
    int i;
    ms[0] = '0; ms[1] = '0; momem[0] = '0; momem[1] = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ack !== 1'b0 || rdat !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: ack %b dat %h, required 0/0", ack, rdat);
    end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < 8; w++) begin
        issue_read(32'h8004_0000 + (32'(c) << 16) + 32'(4*w), 32'h0);
        issue_read(32'h8000_0000 + (32'(c) << 16) + 32'(4*w), 32'h0);
      end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); k = ok_q.pop_front();
      n_cmp++;
      if (!k || a !== e) begin
        n_err++;
        $display("FAIL reset_read #%0d: got %h ack %0b, required %h", i, a, k, e);
      end
      i++;
    end
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h8000_0000;
    #2 rst_n = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort: ack %b, required 0", ack);
    end
    cyc = 0; stb = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_imem_rw();
    logic [31:0] e, a, v;
    logic [7:0]  b;
    bit k;
    int i;
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < 8; w++) set_imem(c, w, $urandom);
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < 8; w++) begin
        b = 8'(255 - 32*w);
        v = ms[c][b -: 32];
        issue_read(32'h8000_0000 + (32'(c) << 16) + 32'(4*w), v);
      end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); k = ok_q.pop_front();
      n_cmp++;
      if (!k || a !== e) begin
        n_err++;
        $display("FAIL imem_rw #%0d: got %h ack %0b, required %h", i, a, k, e);
      end
      i++;
    end
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < 8; w++) set_imem(c, w, 32'h0);
  endtask

  task automatic init_params();
    for (int c = 0; c < 2; c++)
      for (int n = 0; n < 256; n++)
        set_neuron(c, n, '0, 0, 0, 0, 0, 0, 0, 100);
  endtask

  task automatic test_single_synapse();
    logic [31:0] e, a;
    bit k;
    int i;
    set_neuron(0, 5, 256'h2, 0, 0, 0, 5, 0, 0, 5);
    set_imem(0, 7, 32'h0000_0002);
    do_trigger();
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < 8; w++)
        issue_read(32'h8004_0000 + (32'(c) << 16) + 32'(4*w),
                   (c == 0 && w == 7) ? 32'h0000_0020 : 32'h0);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); k = ok_q.pop_front();
      n_cmp++;
      if (!k || a !== e) begin
        n_err++;
        $display("FAIL single_synapse #%0d: got %h ack %0b, required %h", i, a, k, e);
      end
      i++;
    end
  endtask

  task automatic test_weight_leak();
    logic [31:0] e, a;
    bit k;
    int i;
    set_neuron(0, 0, 256'hF, 0, -3, 1, 2, 3, 4, 7);
    set_imem(0, 7, 32'h0000_000F);
    do_trigger();
    issue_read(32'h8004_001C, 32'h0000_0021);
    issue_omem_reads();
    set_neuron(0, 0, 256'hF, 0, -3, 1, 2, 3, 4, 8);
    do_trigger();
    issue_read(32'h8004_001C, 32'h0000_0020);
    issue_omem_reads();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); k = ok_q.pop_front();
      n_cmp++;
      if (!k || a !== e) begin
        n_err++;
        $display("FAIL weight_leak #%0d: got %h ack %0b, required %h", i, a, k, e);
      end
      i++;
    end
  endtask

  task automatic test_negative_sum();
    logic [31:0] e, a;
    bit k;
    int i;
    set_neuron(0, 1, 256'h11, 0, 0, -256, 0, 0, 0, -1);
    set_imem(0, 7, 32'h0000_001F);
    do_trigger();
    issue_read(32'h8004_001C, 32'h0000_0020);
    issue_omem_reads();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); k = ok_q.pop_front();
      n_cmp++;
      if (!k || a !== e) begin
        n_err++;
        $display("FAIL negative_sum #%0d: got %h ack %0b, required %h", i, a, k, e);
      end
      i++;
    end
  endtask

  task automatic test_core_indep();
    logic [31:0] e, a;
    bit k;
    int i;
    set_neuron(0, 1, '0, 0, 0, 0, 0, 0, 0, 100);
    set_imem(0, 7, 32'h0);
    set_neuron(1, 5, 256'h2, 0, 0, 0, 5, 0, 0, 5);
    set_imem(1, 7, 32'h0000_0002);
    do_trigger();
    issue_read(32'h8005_001C, 32'h0000_0020);
    issue_read(32'h8004_001C, 32'h0);
    issue_omem_reads();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); k = ok_q.pop_front();
      n_cmp++;
      if (!k || a !== e) begin
        n_err++;
        $display("FAIL core_indep #%0d: got %h ack %0b, required %h", i, a, k, e);
      end
      i++;
    end
  endtask

  task automatic test_stateless();
    logic [31:0] e, a, r;
    logic [31:0] first [$];
    bit k;
    int i;
    set_imem(0, 7, 32'h0000_000F);
    do_trigger();
    issue_omem_reads();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); k = ok_q.pop_front();
      first.push_back(a);
      n_cmp++;
      if (!k || a !== e) begin
        n_err++;
        $display("FAIL stateless_1st #%0d: got %h ack %0b, required %h", i, a, k, e);
      end
      i++;
    end
    do_trigger();
    issue_omem_reads();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); k = ok_q.pop_front();
      r = first.pop_front();
      n_cmp++;
      if (!k || a !== e || a !== r) begin
        n_err++;
        $display("FAIL stateless_2nd #%0d: got %h ack %0b, required %h (first %h)", i, a, k, e, r);
      end
      i++;
    end
    set_imem(0, 7, 32'h0);
    set_imem(1, 7, 32'h0);
    set_neuron(0, 2, '0, 10, -2, 0, 0, 0, 0, 8);
    do_trigger();
    issue_read(32'h8004_001C, 32'h0000_0004);
    issue_omem_reads();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); k = ok_q.pop_front();
      n_cmp++;
      if (!k || a !== e) begin
        n_err++;
        $display("FAIL stateless_zero #%0d: got %h ack %0b, required %h", i, a, k, e);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sa [6];
    logic [31:0] se [6];
    logic        sw [6];
    logic [31:0] e, a;
    bit k;
    int i;
    sa = '{32'h8001_000C, 32'h8001_000C, 32'h8010_0000,
           32'h8002_0500, 32'h8036_0004, 32'h8004_001C};
    sw = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ms[1][159:128] = 32'hA5C3_0F96;
    se = '{32'h0, 32'hA5C3_0F96, 32'h0, 32'h0, 32'h0, momem[0][31:0]};
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      cyc = 1; stb = 1; we = sw[s]; adr = sa[s]; wdat = 32'hA5C3_0F96;
      @(posedge clk); #1;
      if (sw[s]) begin
        n_cmp++;
        if (ack !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_write_ack: ack %b, required 1", ack);
        end
      end else begin
        exp_q.push_back(se[s]);
        act_q.push_back(rdat);
        ok_q.push_back(ack === 1'b1);
      end
    end
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ack_drop: ack %b, required 0", ack);
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); k = ok_q.pop_front();
      n_cmp++;
      if (!k || a !== e) begin
        n_err++;
        $display("FAIL back_to_back #%0d: got %h ack %0b, required %h", i, a, k, e);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_imem_rw();
    init_params();
    test_single_synapse();
    test_weight_leak();
    test_negative_sum();
    test_core_indep();
    test_stateless();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
